// File: rtl/inst_decode_sb.sv
// inst_decode_sb
// Decode stage for RV64I/RV32I ALU, ALU-immediate, LUI, LOAD and STORE
// instructions. The stage owns the integer register file and presents one
// decoded bundle to execute through a single output register. A per-register
// busy scoreboard stalls RAW and WAW hazards against writes that are still
// in flight to write-back.
//
// Optional feature macro: INST_DECODE_WB_BYPASS_EN
//   defined   -> same-cycle write-back forwarding into the operands, and hazard
//                release in the write-back cycle
//   undefined -> operands come from the register file only, and a busy
//                register releases the cycle after its write-back
//
// Ports
//   CLK, reset            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     fetch handshake for inst
//   inst                  32-bit instruction word
//   wb_en/wb_rd/wb_value  write-back port (register write + busy clear)
//   out_valid/out_ready   execute handshake for the decoded bundle
//   rd, rs1, rs2          register indices
//   funct3, funct7        instruction function fields
//   imm                   sign-extended I/S/U immediate
//   op1, op2              ALU operands
//   store_data            rs2 value for STORE
//   write_back, imm_flag, mem_acc, load_flag, store_flag, illegal  decode flags
module inst_decode_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] store_data,
  output logic            write_back,
  output logic            imm_flag,
  output logic            mem_acc,
  output logic            load_flag,
  output logic            store_flag,
  output logic            illegal
);

  localparam int IW = $clog2(NREG);

  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic            outValid_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [XLEN-1:0] imm_q, op1_q, op2_q, storeData_q;
  logic            writeBack_q, immFlag_q, memAcc_q, loadFlag_q, storeFlag_q, illegal_q;

  logic [6:0]      opcode;
  logic [4:0]      instRd, instRs1, instRs2;
  logic            isAlu, isAluImm, isLui, isLoad, isStore, isIllegal;
  logic            useRs1, useRs2;
  logic [XLEN-1:0] immI, immS, immU;
  logic [XLEN-1:0] decImm, decOp1, decOp2, decStoreData;
  logic            decWriteBack;
  logic            hazard, accept;

  // Indices at or above NREG (possible when NREG=16) read as zero and are
  // never busy; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] readReg(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != 5'd0 && 32'(idx) < NREG) begin
      val = regs_q[idx[IW-1:0]];
`ifdef INST_DECODE_WB_BYPASS_EN
      if (wb_en && wb_rd == idx) val = wb_value;
`endif
    end
    return val;
  endfunction

  function automatic logic isBusy(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREG) && busy_q[idx[IW-1:0]];
  endfunction

  // A busy register counts as released in the write-back cycle itself only
  // when forwarding is built in; otherwise release waits for the register write.
  function automatic logic wbReleases(input logic [4:0] idx);
`ifdef INST_DECODE_WB_BYPASS_EN
    return wb_en && (wb_rd == idx);
`else
    return 1'b0 & idx[0];
`endif
  endfunction

  // Combinational decode of the offered instruction into the next bundle.
  always_comb begin
    opcode  = inst[6:0];
    instRd  = inst[11:7];
    instRs1 = inst[19:15];
    instRs2 = inst[24:20];

    isAlu     = (opcode == OP_ALU);
    isAluImm  = (opcode == OP_ALU_IMM);
    isLui     = (opcode == OP_LUI);
    isLoad    = (opcode == OP_LOAD);
    isStore   = (opcode == OP_STORE);
    isIllegal = !(isAlu || isAluImm || isLui || isLoad || isStore);

    useRs1 = isAlu || isAluImm || isLoad || isStore;
    useRs2 = isAlu || isStore;

    immI = {XLEN{inst[31]}};
    immI[11:0] = inst[31:20];
    immS = {XLEN{inst[31]}};
    immS[11:0] = {inst[31:25], inst[11:7]};
    immU = {XLEN{inst[31]}};
    immU[31:0] = {inst[31:12], 12'b0};

    decImm       = '0;
    decOp1       = '0;
    decOp2       = '0;
    decStoreData = '0;
    decWriteBack = 1'b0;
    if (isAlu) begin
      decOp1       = readReg(instRs1);
      decOp2       = readReg(instRs2);
      decWriteBack = 1'b1;
    end else if (isAluImm || isLoad) begin
      decImm       = immI;
      decOp1       = readReg(instRs1);
      decOp2       = immI;
      decWriteBack = 1'b1;
    end else if (isLui) begin
      decImm       = immU;
      decOp2       = immU;
      decWriteBack = 1'b1;
    end else if (isStore) begin
      decImm       = immS;
      decOp1       = readReg(instRs1);
      decOp2       = immS;
      decStoreData = readReg(instRs2);
    end
  end

  // Hazard check covers RAW on used sources and WAW on the destination.
  always_comb begin
    hazard = (useRs1 && isBusy(instRs1) && !wbReleases(instRs1)) ||
             (useRs2 && isBusy(instRs2) && !wbReleases(instRs2)) ||
             (decWriteBack && isBusy(instRd) && !wbReleases(instRd));
    in_ready = !reset && !hazard && (!outValid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  // Scoreboard next state: the clear is applied first so that a set on the
  // same index in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && 32'(wb_rd) < NREG) busy_d[wb_rd[IW-1:0]] = 1'b0;
    if (accept && decWriteBack && instRd != 5'd0 && 32'(instRd) < NREG)
      busy_d[instRd[IW-1:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register file write port; x0 and out-of-range indices are dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0 && 32'(wb_rd) < NREG) begin
      regs_q[wb_rd[IW-1:0]] <= wb_value;
    end
  end

  // Scoreboard register.
  always_ff @(posedge CLK) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // One-entry output register: loads on accept, drains when execute takes
  // the bundle, and otherwise holds every field stable.
  always_ff @(posedge CLK) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      storeData_q <= '0;
      writeBack_q <= 1'b0;
      immFlag_q   <= 1'b0;
      memAcc_q    <= 1'b0;
      loadFlag_q  <= 1'b0;
      storeFlag_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      outValid_q  <= 1'b1;
      rd_q        <= instRd;
      rs1_q       <= instRs1;
      rs2_q       <= instRs2;
      funct3_q    <= inst[14:12];
      funct7_q    <= inst[31:25];
      imm_q       <= decImm;
      op1_q       <= decOp1;
      op2_q       <= decOp2;
      storeData_q <= decStoreData;
      writeBack_q <= decWriteBack;
      immFlag_q   <= isAluImm || isLui;
      memAcc_q    <= isLoad || isStore;
      loadFlag_q  <= isLoad;
      storeFlag_q <= isStore;
      illegal_q   <= isIllegal;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid  = outValid_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign funct3     = funct3_q;
  assign funct7     = funct7_q;
  assign imm        = imm_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign store_data = storeData_q;
  assign write_back = writeBack_q;
  assign imm_flag   = immFlag_q;
  assign mem_acc    = memAcc_q;
  assign load_flag  = loadFlag_q;
  assign store_flag = storeFlag_q;
  assign illegal    = illegal_q;

endmodule
